// File: rtl/reversing_bits_pkg.sv
// Shared types and constants for the bit-reversing arbiter.
// Pure declarations: no logic, no latency, no flow control.
package reversing_bits_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the index after i_ptr, wrapping at NUM_REQ-1.
// Zero latency; grants nothing while i_en is low.
module rr_arbiter
#(
    parameter int NUM_REQ = 2
)
(
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        // k runs 1..NUM_REQ so the last-granted requester is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reversing_bits_arbiter.sv
// Shares one bit-reverser among NUM_REQ requesters round-robin; result valid 1 cycle after transfer.
// req_ready drops to zero while a held result is stalled; optional grant counters via REVERSING_BITS_ARBITER_STATS_EN.
module reversing_bits_arbiter
    import reversing_bits_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [$clog2(NUM_REQ)-1:0]    dout_src
`ifdef REVERSING_BITS_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]      grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [IDX_W-1:0]      r_src;
    logic [IDX_W-1:0]      r_ptr;

    logic                  w_accept;
    logic                  w_xfer;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_rev;

    // A held result being drained this cycle frees the register for a new word
    assign w_accept = (r_state == EMPTY) || dout_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_accept),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |w_gnt;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_rev[i] = w_word[DATA_WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_dout  <= '0;
            r_src   <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_state <= FULL;
            r_dout  <= w_rev;
            r_src   <= w_idx;
            r_ptr   <= w_idx;
        end else if (dout_ready) begin
            r_state <= EMPTY;
        end
    end

    assign dout_valid = (r_state == FULL);
    assign dout       = r_dout;
    assign dout_src   = r_src;

`ifdef REVERSING_BITS_ARBITER_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_reversing_bits_arbiter.sv
// Directed scoreboard bench for reversing_bits_arbiter (DATA_WIDTH=32, NUM_REQ=2).
module tb_reversing_bits_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout;
    logic        dout_src;
`ifdef REVERSING_BITS_ARBITER_STATS_EN
    logic [31:0] grant_cnt;
`endif

    reversing_bits_arbiter #(
        .DATA_WIDTH (32),
        .NUM_REQ    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_src   (dout_src)
`ifdef REVERSING_BITS_ARBITER_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        src;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; check the grant and valid, and queue the expected result
    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                        input logic rdy, input logic [1:0] exp_rdy, input logic [31:0] exp_d,
                        input logic exp_vld);
        exp_t e;
        req_valid  = v;
        req_data   = {d1, d0};
        dout_ready = rdy;
        @(negedge clk);
        chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
        chk("dout_valid", {63'd0, dout_valid}, {63'd0, exp_vld});
        if (exp_rdy != 2'b00) begin
            e.d   = exp_d;
            e.src = exp_rdy[1];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got dout 0x%0h src %0d, expected no output", dout, dout_src);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", {32'd0, dout}, {32'd0, e.d});
                chk("dout_src", {63'd0, dout_src}, {63'd0, e.src});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_dout_src", {63'd0, dout_src}, 64'd0);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single word, one-cycle latency
        step(2'b01, 32'h12345678, 32'h0, 1'b1, 2'b01, 32'h1E6A2C48, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1);

        // stall while FULL, then release with no bubble
        step(2'b01, 32'hA5A5A5A5, 32'h0, 1'b1, 2'b01, 32'hA5A5A5A5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b10, 32'h0, 32'h3, 1'b0, 2'b00, 32'h0, 1'b1);
            chk("hold_dout", {32'd0, dout}, 64'hA5A5A5A5);
            chk("hold_src", {63'd0, dout_src}, 64'd0);
        end
        step(2'b10, 32'h0, 32'h3, 1'b1, 2'b10, 32'hC0000000, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1);

        // reset while FULL discards the result
        step(2'b01, 32'h80000001, 32'h0, 1'b1, 2'b01, 32'h80000001, 1'b0);
        req_valid  = 2'b00;
        dout_ready = 1'b0;
        reset      = 1'b1;
        #1;
        chk("midrst_dout_valid", {63'd0, dout_valid}, 64'd0);
        chk("midrst_dout", {32'd0, dout}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // both valid: requester 0 first, then alternation
        step(2'b11, 32'h1, 32'hF, 1'b1, 2'b01, 32'h80000000, 1'b0);
        step(2'b11, 32'h1, 32'hF, 1'b1, 2'b10, 32'hF0000000, 1'b1);
        step(2'b11, 32'h1, 32'hF, 1'b1, 2'b01, 32'h80000000, 1'b1);
        step(2'b11, 32'h1, 32'hF, 1'b1, 2'b10, 32'hF0000000, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1);

        // lone requester granted even when the pointer already sits on it
        step(2'b10, 32'h0, 32'h00000100, 1'b1, 2'b10, 32'h00800000, 1'b0);
        step(2'b10, 32'h0, 32'h00000100, 1'b1, 2'b10, 32'h00800000, 1'b1);
        step(2'b01, 32'hFFFF0000, 32'h0, 1'b1, 2'b01, 32'h0000FFFF, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

`ifdef REVERSING_BITS_ARBITER_STATS_EN
        reset = 1'b1;
        #1;
        chk("cnt_rst", {32'd0, grant_cnt}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(2'b10, 32'h0, 32'h1, 1'b1, 2'b10, 32'h80000000, 1'b0);
        step(2'b10, 32'h0, 32'h1, 1'b1, 2'b10, 32'h80000000, 1'b1);
        step(2'b10, 32'h0, 32'h1, 1'b1, 2'b10, 32'h80000000, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1);
        chk("cnt_req1", {48'd0, grant_cnt[31:16]}, 64'd3);
        chk("cnt_req0", {48'd0, grant_cnt[15:0]}, 64'd0);
        chk("sb_empty_stats", 64'(sb.size()), 64'd0);
        mon_en     = 1'b0;
        req_valid  = 2'b10;
        dout_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_sat", {48'd0, grant_cnt[31:16]}, 64'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("cnt_sat_hold", {48'd0, grant_cnt[31:16]}, 64'hFFFF);
        req_valid = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
